// File: rtl/opload_pkg.sv
// Shared definitions for the keypad operand loader: key codes, FSM state
// encoding and keypad field positions.
package opload_pkg;

   // Keypad byte layout: [7]=pressed, [4:0]=code
   localparam int KEY_PRESS_BIT = 7;
   localparam int KEY_CODE_MSB  = 4;
   localparam int KEY_CODE_LSB  = 0;
   localparam int KEY_CODE_W    = KEY_CODE_MSB - KEY_CODE_LSB + 1;

   // Command codes; 0x00-0x0F are hex digits, anything else not listed is ignored
   localparam logic [KEY_CODE_W-1:0] KEY_ENTER = 5'h10;
   localparam logic [KEY_CODE_W-1:0] KEY_CLEAR = 5'h11;
   localparam logic [KEY_CODE_W-1:0] KEY_BKSP  = 5'h12;

   typedef enum logic [1:0] {
      S_ENTRY = 2'd0,
      S_WRITE = 2'd1,
      S_GO    = 2'd2
   } state_t;

   // Hex digit codes have the top code bit clear
   function automatic logic is_digit(input logic [KEY_CODE_W-1:0] code);
      return (code[KEY_CODE_W-1] == 1'b0);
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Keypad synchroniser and debouncer. The raw keypad byte is double-flopped,
// then a press is accepted once the pressed bit and code have been stable for
// DEBOUNCE_CYC consecutive samples. A new accept is only armed after the keypad
// has been seen released and stable for DEBOUNCE_CYC samples, so one physical
// press yields one key_acc pulse. The arm flag starts cleared so that a key
// held through reset is not taken as a press.
module key_debouncer
   import opload_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16
)(
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [7:0]            keypad,
   output logic                  key_acc,
   output logic [KEY_CODE_W-1:0] key_code
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0]  CNT_HIT = CNT_W'(DEBOUNCE_CYC - 1);

   logic [7:0]            r_sync1;
   logic [7:0]            r_sync2;
   logic [7:0]            r_cand;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_armed;
   logic                  r_acc;
   logic [KEY_CODE_W-1:0] r_code;

   logic                  w_same;
   logic                  w_hit;

   assign w_same = (r_sync2 == r_cand);
   // The sample that brings the run length up to DEBOUNCE_CYC
   assign w_hit  = w_same && (r_cnt == CNT_HIT);

   // two-flop synchroniser for the asynchronous keypad lines
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= keypad;
         r_sync2 <= r_sync1;
      end
   end

   // track the current candidate level and how long it has been stable
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_cand <= '0;
         r_cnt  <= '0;
      end else if (!w_same) begin
         r_cand <= r_sync2;
         r_cnt  <= CNT_W'(1);
      end else if (r_cnt != CNT_MAX) begin
         r_cnt  <= r_cnt + CNT_W'(1);
      end
   end

   // issue one accept per stable press, re-arm on a stable release
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_armed <= 1'b0;
         r_acc   <= 1'b0;
         r_code  <= '0;
      end else begin
         r_acc <= 1'b0;
         if (w_hit) begin
            if (r_cand[KEY_PRESS_BIT]) begin
               if (r_armed) begin
                  r_acc   <= 1'b1;
                  r_code  <= r_cand[KEY_CODE_MSB:KEY_CODE_LSB];
                  r_armed <= 1'b0;
               end
            end else begin
               r_armed <= 1'b1;
            end
         end
      end
   end

   assign key_acc  = r_acc;
   assign key_code = r_code;

endmodule

// File: rtl/keypad_operand_loader.sv
// Keypad-driven operand loader for the calculator top. Debounced keys build a
// hex entry; ENTER writes it to data memory at BASE_ADDR+slot through a
// valid/ready port; after NUM_OPS operands cpu_go pulses for one cycle.
// Optional build macro KEYPAD_LOADER_DROP_CNT_EN adds the drop_cnt output,
// a saturating count of keys dropped while busy.
module keypad_operand_loader
   import opload_pkg::*;
#(
   parameter int          DATA_W       = 16,
   parameter int          NUM_OPS      = 3,
   parameter logic [15:0] BASE_ADDR    = 16'h0000,
   parameter int          DEBOUNCE_CYC = 16
)(
   input  logic              CLK,
   input  logic              reset,
   input  logic [7:0]        keypad,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [15:0]       wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_go,
   output logic              busy,
   output logic [3:0]        slot_idx,
   output logic [DATA_W-1:0] entry
`ifdef KEYPAD_LOADER_DROP_CNT_EN
   ,
   output logic [7:0]        drop_cnt
`endif
);

   localparam logic [3:0] LAST_SLOT = 4'(NUM_OPS - 1);

   logic                  w_key_acc;
   logic [KEY_CODE_W-1:0] w_key_code;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_W-1:0]     r_entry;
   logic [DATA_W-1:0]     w_entry_nxt;
   logic [3:0]            r_slot;
   logic [3:0]            w_slot_nxt;
   logic                  r_wr_valid;
   logic                  w_wr_valid_nxt;
   logic [15:0]           r_wr_addr;
   logic [15:0]           w_wr_addr_nxt;
   logic [DATA_W-1:0]     r_wr_data;
   logic [DATA_W-1:0]     w_wr_data_nxt;

   key_debouncer #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_deb (
      .CLK      (CLK),
      .reset    (reset),
      .keypad   (keypad),
      .key_acc  (w_key_acc),
      .key_code (w_key_code)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) r_state <= S_ENTRY;
      else        r_state <= w_state_nxt;
   end

   // entry, slot and write-port registers
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_entry    <= '0;
         r_slot     <= '0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_entry    <= w_entry_nxt;
         r_slot     <= w_slot_nxt;
         r_wr_valid <= w_wr_valid_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
      end
   end

   // next-state and datapath updates; keys outside S_ENTRY fall through unused
   always_comb begin
      w_state_nxt    = r_state;
      w_entry_nxt    = r_entry;
      w_slot_nxt     = r_slot;
      w_wr_valid_nxt = r_wr_valid;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;
      case (r_state)
         S_ENTRY: begin
            if (w_key_acc) begin
               if (is_digit(w_key_code)) begin
                  w_entry_nxt = {r_entry[DATA_W-5:0], w_key_code[3:0]};
               end else begin
                  case (w_key_code)
                     KEY_BKSP:  w_entry_nxt = r_entry >> 4;
                     KEY_CLEAR: begin
                        w_entry_nxt = '0;
                        w_slot_nxt  = '0;
                     end
                     KEY_ENTER: begin
                        w_wr_addr_nxt  = BASE_ADDR + {12'd0, r_slot};
                        w_wr_data_nxt  = r_entry;
                        w_wr_valid_nxt = 1'b1;
                        w_state_nxt    = S_WRITE;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_WRITE: begin
            if (r_wr_valid && wr_ready) begin
               w_wr_valid_nxt = 1'b0;
               w_entry_nxt    = '0;
               if (r_slot == LAST_SLOT) begin
                  w_slot_nxt  = '0;
                  w_state_nxt = S_GO;
               end else begin
                  w_slot_nxt  = r_slot + 4'd1;
                  w_state_nxt = S_ENTRY;
               end
            end
         end
         S_GO:    w_state_nxt = S_ENTRY;
         default: w_state_nxt = S_ENTRY;
      endcase
   end

`ifdef KEYPAD_LOADER_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   // saturating count of keys that arrive during a write or go cycle
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset)
         r_drop_cnt <= '0;
      else if (w_key_acc && (r_state != S_ENTRY) && (r_drop_cnt != 8'hFF))
         r_drop_cnt <= r_drop_cnt + 8'd1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign wr_valid = r_wr_valid;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign cpu_go   = (r_state == S_GO);
   assign busy     = (r_state != S_ENTRY);
   assign slot_idx = r_slot;
   assign entry    = r_entry;

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Directed bench for keypad_operand_loader (DEBOUNCE_CYC=4, DATA_W=16,
// NUM_OPS=3, BASE_ADDR=0). Build with KEYPAD_LOADER_DROP_CNT_EN to also
// exercise drop_cnt.
module tb_keypad_operand_loader;
   import opload_pkg::*;

   logic        CLK;
   logic        reset;
   logic [7:0]  keypad;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        cpu_go;
   logic        busy;
   logic [3:0]  slot_idx;
   logic [15:0] entry;
`ifdef KEYPAD_LOADER_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   keypad_operand_loader #(
      .DATA_W       (16),
      .NUM_OPS      (3),
      .BASE_ADDR    (16'h0000),
      .DEBOUNCE_CYC (4)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .keypad   (keypad),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_go   (cpu_go),
      .busy     (busy),
      .slot_idx (slot_idx),
      .entry    (entry)
`ifdef KEYPAD_LOADER_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Write and go logs, captured mid-cycle before the completing edge
   logic [15:0] log_addr[$];
   logic [15:0] log_data[$];
   int          log_cyc[$];
   int          go_cyc[$];

   always @(negedge CLK) begin
      if (reset && wr_valid && wr_ready) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
         log_cyc.push_back(cyc);
      end
      if (cpu_go) go_cyc.push_back(cyc);
   end

   // Write-port hold monitor while a write is stalled
   logic        mon_en = 1'b0;
   logic        pv     = 1'b0;
   logic [15:0] pa, pd;
   int          stab_err = 0;

   always @(negedge CLK) begin
      if (mon_en) begin
         if (pv && !(wr_valid === 1'b1 && wr_addr === pa && wr_data === pd))
            stab_err++;
         pv = wr_valid && !wr_ready;
         pa = wr_addr;
         pd = wr_data;
      end else begin
         pv = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic [4:0] c);
      @(negedge CLK);
      keypad = {1'b1, 2'b00, c};
      repeat (12) @(negedge CLK);
      keypad = 8'h00;
      repeat (12) @(negedge CLK);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, {31'd0, wr_valid}, 32'd0);
      chk({tag, "_addr"},  {16'd0, wr_addr},  32'd0);
      chk({tag, "_data"},  {16'd0, wr_data},  32'd0);
      chk({tag, "_go"},    {31'd0, cpu_go},   32'd0);
      chk({tag, "_busy"},  {31'd0, busy},     32'd0);
      chk({tag, "_slot"},  {28'd0, slot_idx}, 32'd0);
      chk({tag, "_entry"}, {16'd0, entry},    32'd0);
`ifdef KEYPAD_LOADER_DROP_CNT_EN
      chk({tag, "_drop"},  {24'd0, drop_cnt}, 32'd0);
`endif
   endtask

   typedef struct {
      logic [4:0]  code;
      logic [15:0] exp_entry;
      logic [3:0]  exp_slot;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{5'h01,     16'h0001, 4'd0};
      tbl[1]  = '{5'h02,     16'h0012, 4'd0};
      tbl[2]  = '{5'h03,     16'h0123, 4'd0};
      tbl[3]  = '{5'h04,     16'h1234, 4'd0};
      tbl[4]  = '{KEY_ENTER, 16'h0000, 4'd1};
      tbl[5]  = '{5'h01,     16'h0001, 4'd1};
      tbl[6]  = '{5'h02,     16'h0012, 4'd1};
      tbl[7]  = '{5'h03,     16'h0123, 4'd1};
      tbl[8]  = '{5'h04,     16'h1234, 4'd1};
      tbl[9]  = '{5'h05,     16'h2345, 4'd1};
      tbl[10] = '{KEY_BKSP,  16'h0234, 4'd1};
      tbl[11] = '{5'h15,     16'h0234, 4'd1};
      tbl[12] = '{KEY_CLEAR, 16'h0000, 4'd0};

      reset    = 1'b0;
      keypad   = 8'h00;
      wr_ready = 1'b1;
      repeat (3) @(negedge CLK);
      chk_idle("reset");
      reset = 1'b1;
      repeat (10) @(negedge CLK);

      // Entry editing, first write, BKSP/ignored/CLEAR
      for (int unsigned i = 0; i < 13; i++) begin
         press(tbl[i].code);
         chk($sformatf("tbl%0d_entry", i), {16'd0, entry},    {16'd0, tbl[i].exp_entry});
         chk($sformatf("tbl%0d_slot", i),  {28'd0, slot_idx}, {28'd0, tbl[i].exp_slot});
      end
      chk("t1_nwr", log_addr.size(), 32'd1);
      if (log_addr.size() >= 1) begin
         chk("t1_addr", {16'd0, log_addr[0]}, 32'h0000);
         chk("t1_data", {16'd0, log_data[0]}, 32'h1234);
      end
      chk("t1_nogo", go_cyc.size(), 32'd0);
      log_addr.delete(); log_data.delete(); log_cyc.delete(); go_cyc.delete();

      // Three operands then cpu_go
      press(5'h05); press(KEY_ENTER);
      press(5'h07); press(KEY_ENTER);
      press(5'h01); press(KEY_ENTER);
      chk("t2_nwr", log_addr.size(), 32'd3);
      if (log_addr.size() == 3) begin
         chk("t2_addr0", {16'd0, log_addr[0]}, 32'd0);
         chk("t2_data0", {16'd0, log_data[0]}, 32'h0005);
         chk("t2_addr1", {16'd0, log_addr[1]}, 32'd1);
         chk("t2_data1", {16'd0, log_data[1]}, 32'h0007);
         chk("t2_addr2", {16'd0, log_addr[2]}, 32'd2);
         chk("t2_data2", {16'd0, log_data[2]}, 32'h0001);
      end
      chk("t2_ngo", go_cyc.size(), 32'd1);
      if (go_cyc.size() == 1 && log_cyc.size() == 3)
         chk("t2_go_cyc", go_cyc[0], log_cyc[2] + 1);
      chk("t2_slot", {28'd0, slot_idx}, 32'd0);
      chk("t2_busy", {31'd0, busy}, 32'd0);
      log_addr.delete(); log_data.delete(); log_cyc.delete(); go_cyc.delete();

      // Stalled write: port held, keys dropped
      wr_ready = 1'b0;
      press(5'h09);
      press(KEY_ENTER);
      chk("t3_valid", {31'd0, wr_valid}, 32'd1);
      mon_en = 1'b1;
      press(5'h03);
      press(5'h04);
      mon_en = 1'b0;
      chk("t3_hold", stab_err, 32'd0);
      chk("t3_valid_held", {31'd0, wr_valid}, 32'd1);
      chk("t3_addr", {16'd0, wr_addr}, 32'd0);
      chk("t3_data", {16'd0, wr_data}, 32'h0009);
      chk("t3_entry", {16'd0, entry}, 32'h0009);
      chk("t3_busy", {31'd0, busy}, 32'd1);
`ifdef KEYPAD_LOADER_DROP_CNT_EN
      chk("t3_drop", {24'd0, drop_cnt}, 32'd2);
`endif
      wr_ready = 1'b1;
      repeat (3) @(negedge CLK);
      chk("t3_nwr", log_addr.size(), 32'd1);
      chk("t3_done_valid", {31'd0, wr_valid}, 32'd0);
      chk("t3_done_entry", {16'd0, entry}, 32'd0);
      chk("t3_done_slot", {28'd0, slot_idx}, 32'd1);
      log_addr.delete(); log_data.delete(); log_cyc.delete(); go_cyc.delete();

      // Bouncing key: one accept only
      for (int unsigned i = 0; i < 20; i++) begin
         keypad = (i % 2 == 0) ? 8'h82 : 8'h00;
         @(negedge CLK);
      end
      keypad = 8'h82;
      repeat (6) @(negedge CLK);
      keypad = 8'h00;
      repeat (12) @(negedge CLK);
      chk("t4_entry", {16'd0, entry}, 32'h0002);

      // Reset during a stalled handshake
      wr_ready = 1'b0;
      press(KEY_ENTER);
      chk("t6_valid_pre", {31'd0, wr_valid}, 32'd1);
      chk("t6_addr_pre", {16'd0, wr_addr}, 32'd1);
      @(negedge CLK);
      #2 reset = 1'b0;
      #1 chk("t6_valid_async", {31'd0, wr_valid}, 32'd0);
      chk_idle("t6_in_reset");
      repeat (2) @(negedge CLK);
      reset = 1'b1;
      repeat (10) @(negedge CLK);
      chk_idle("t6_after");
      wr_ready = 1'b1;
      press(5'h03);
      press(KEY_ENTER);
      chk("t6_nwr", log_addr.size(), 32'd1);
      if (log_addr.size() == 1) begin
         chk("t6_addr", {16'd0, log_addr[0]}, 32'd0);
         chk("t6_data", {16'd0, log_data[0]}, 32'h0003);
      end
      chk("t6_slot", {28'd0, slot_idx}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
